// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: FSM states, fill pattern modes
// and the mode field width.
package mem_fill_pkg;

  localparam int MODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  typedef enum logic [MODE_W-1:0] {
    IDENTITY   = 2'd0,
    DESCENDING = 2'd1,
    CONSTANT   = 2'd2,
    XOR        = 2'd3
  } mode_t;

endpackage

// File: rtl/mem_fill_pattern.sv
// Combinational write-data generator: turns the fill index into the data
// word for the selected pattern.
module mem_fill_pattern
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] fill_val,
  output logic [DATA_W-1:0] wrdata
);

  logic [ADDR_W-1:0] src;
  logic [DATA_W-1:0] src_ext;

  // Descending data is (2^ADDR_W-1-idx), which is simply the inverted index.
  always_comb begin
    src = idx;
    if (mode_t'(mode) == DESCENDING) src = ~idx;
  end

  // Index is zero-extended or truncated to the data width.
  generate
    if (DATA_W > ADDR_W) begin : g_extend
      assign src_ext = {{(DATA_W-ADDR_W){1'b0}}, src};
    end else if (DATA_W == ADDR_W) begin : g_equal
      assign src_ext = src;
    end else begin : g_truncate
      assign src_ext = src[DATA_W-1:0];
    end
  endgenerate

  always_comb begin
    wrdata = src_ext;
    case (mode_t'(mode))
      CONSTANT: wrdata = fill_val;
      XOR:      wrdata = src_ext ^ fill_val;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// Memory fill engine: on a start request writes len consecutive words
// (wrapping addresses) with a pattern, one per cycle, then pulses done.
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, base_q, len_q, addr_hold, fill_addr;
  logic [MODE_W-1:0] mode_q;
  logic [DATA_W-1:0] fill_q, wrdata_hold, pat_data;
  logic              done_q, accept, finish, last;

  mem_fill_pattern #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pattern (
    .mode    (mode_q),
    .idx     (idx),
    .fill_val(fill_q),
    .wrdata  (pat_data)
  );

  // len=0 means a full 2^ADDR_W fill, so the last index is len-1 modulo depth.
  assign last      = (idx == len_q - ADDR_W'(1));
  assign fill_addr = base_q + idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = FILL;
          accept     = 1'b1;
        end
      end
      FILL: begin
        if (abort || last) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Last presented address/data are captured so the outputs hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      fill_q      <= '0;
      addr_hold   <= '0;
      wrdata_hold <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        idx    <= '0;
        base_q <= base;
        len_q  <= len;
        mode_q <= mode;
        fill_q <= fill_val;
      end else if (state == FILL) begin
        idx         <= idx + ADDR_W'(1);
        addr_hold   <= fill_addr;
        wrdata_hold <= pat_data;
      end
    end
  end

  assign rdy    = (state == IDLE);
  assign wren   = (state == FILL);
  assign addr   = wren ? fill_addr : addr_hold;
  assign wrdata = wren ? pat_data : wrdata_hold;
  assign done   = done_q;

endmodule

// File: tb/tb_mem_fill.sv
// Directed self-checking bench for mem_fill at default widths plus a
// narrow ADDR_W=4 / DATA_W=12 instance.
module tb_mem_fill;

  logic       clk;
  logic       rst;
  logic       en, abort;
  logic [1:0] mode;
  logic [7:0] base, len, fill_val;
  logic       rdy, wren, done;
  logic [7:0] addr, wrdata;

  logic        s_en, s_abort;
  logic [1:0]  s_mode;
  logic [3:0]  s_base, s_len, s_addr;
  logic [11:0] s_fill, s_wrdata;
  logic        s_rdy, s_wren, s_done;

  int assertCount = 0;
  int failCount   = 0;

  int xorAddr[4] = '{32'hFE, 32'hFF, 32'h00, 32'h01};
  int xorData[4] = '{32'hA5, 32'hA4, 32'hA7, 32'hA6};

  mem_fill dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .base(base), .len(len),
    .fill_val(fill_val), .abort(abort), .rdy(rdy), .addr(addr),
    .wrdata(wrdata), .wren(wren), .done(done)
  );

  mem_fill #(.ADDR_W(4), .DATA_W(12)) dut_small (
    .clk(clk), .rst(rst), .en(s_en), .mode(s_mode), .base(s_base),
    .len(s_len), .fill_val(s_fill), .abort(s_abort), .rdy(s_rdy),
    .addr(s_addr), .wrdata(s_wrdata), .wren(s_wren), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge, where inputs also change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic [7:0] b, input logic [7:0] l,
                               input logic [7:0] f);
    en = e; mode = m; base = b; len = l; fill_val = f;
  endtask

  task automatic expectWrite(input string tag, input int a, input int d);
    checkOutput({tag, "_wren"}, 32'(wren), 1);
    checkOutput({tag, "_rdy"}, 32'(rdy), 0);
    checkOutput({tag, "_addr"}, 32'(addr), a);
    checkOutput({tag, "_data"}, 32'(wrdata), d);
  endtask

  task automatic expectIdle(input string tag, input int d);
    checkOutput({tag, "_rdy"}, 32'(rdy), 1);
    checkOutput({tag, "_wren"}, 32'(wren), 0);
    checkOutput({tag, "_done"}, 32'(done), d);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    s_en = 0; s_abort = 0; s_mode = 0; s_base = 0; s_len = 0; s_fill = 0;
    tick();
    tick();
    rst = 1'b0;
    expectIdle("reset", 0);
    checkOutput("reset_addr", 32'(addr), 0);
    checkOutput("reset_data", 32'(wrdata), 0);

    // Full 256-entry identity fill
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    en = 0;
    for (int i = 0; i < 256; i++) begin
      expectWrite("full", i, i);
      tick();
    end
    expectIdle("full_end", 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expectIdle("full_idle", 0);
    end
    checkOutput("full_hold_addr", 32'(addr), 255);
    checkOutput("full_hold_data", 32'(wrdata), 255);

    // XOR pattern with address wrap
    applyStimulus(1, 3, 8'hFE, 8'd4, 8'hA5);
    tick();
    en = 0;
    for (int i = 0; i < 4; i++) begin
      expectWrite("xor", xorAddr[i], xorData[i]);
      tick();
    end
    expectIdle("xor_end", 1);
    abort = 1;
    tick();
    abort = 0;
    expectIdle("idle_abort", 0);
    tick();
    expectIdle("idle_abort2", 0);

    // Constant fill, aborted on third write, en pulses ignored
    applyStimulus(1, 2, 8'h10, 8'd10, 8'h3C);
    tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      expectWrite("const", 16 + i, 32'h3C);
      if (i == 0) applyStimulus(1, 0, 8'h80, 8'd1, 8'h00);
      else en = 0;
      if (i == 2) abort = 1;
      tick();
    end
    abort = 0;
    expectIdle("const_end", 1);
    checkOutput("const_hold_addr", 32'(addr), 32'h12);
    checkOutput("const_hold_data", 32'(wrdata), 32'h3C);
    tick();
    expectIdle("const_after", 0);

    // Descending fill, back-to-back restart, abort on final write
    applyStimulus(1, 1, 8'h40, 8'd3, 8'h00);
    tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      expectWrite("desc", 32'h40 + i, 255 - i);
      tick();
    end
    expectIdle("desc_end", 1);
    applyStimulus(1, 0, 8'h50, 8'd2, 8'h00);
    tick();
    en = 0;
    expectWrite("b2b0", 32'h50, 0);
    tick();
    expectWrite("b2b1", 32'h51, 1);
    abort = 1;
    tick();
    abort = 0;
    expectIdle("b2b_end", 1);
    tick();
    expectIdle("b2b_after", 0);

    // Reset mid-fill has priority over en and abort
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    en = 0;
    repeat (100) tick();
    expectWrite("mid", 100, 100);
    rst = 1; en = 1; abort = 1;
    tick();
    rst = 0; en = 0; abort = 0;
    expectIdle("mid_rst", 0);
    checkOutput("mid_rst_addr", 32'(addr), 0);
    checkOutput("mid_rst_data", 32'(wrdata), 0);
    tick();
    expectIdle("mid_rst2", 0);

    // Narrow instance: 16 writes, data zero-extended to 12 bits
    s_en = 1;
    tick();
    s_en = 0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("small_wren", 32'(s_wren), 1);
      checkOutput("small_addr", 32'(s_addr), i);
      checkOutput("small_data", 32'(s_wrdata), i);
      tick();
    end
    checkOutput("small_done", 32'(s_done), 1);
    checkOutput("small_rdy", 32'(s_rdy), 1);
    checkOutput("small_wren_end", 32'(s_wren), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_fill.md
MEM_FILL -- requirements
Module: mem_fill

Interface
REQ-001 Parameter ADDR_W, default 8, address width; depth = 2^ADDR_W.
REQ-002 Parameter DATA_W, default 8, write-data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  start request; accepted only when rdy=1.
REQ-006 mode  input  2  fill pattern, sampled at acceptance.
REQ-007 base  input  ADDR_W  first write address, sampled at acceptance.
REQ-008 len  input  ADDR_W  write count; 0 means 2^ADDR_W; sampled at acceptance.
REQ-009 fill_val  input  DATA_W  constant/XOR operand, sampled at acceptance.
REQ-010 abort  input  1  terminate an in-progress fill.
REQ-011 rdy  output  1  high when idle and able to accept en.
REQ-012 addr  output  ADDR_W  memory write address.
REQ-013 wrdata  output  DATA_W  memory write data.
REQ-014 wren  output  1  memory write enable.
REQ-015 done  output  1  one-cycle pulse on completion or abort.

Function
REQ-016 FSM states: IDLE, FILL; encoded as a package enum.
REQ-017 IDLE: rdy=1, wren=0; en=1 on an edge latches mode/base/len/fill_val, clears index idx to 0, and enters FILL.
REQ-018 en while rdy=0 is ignored; latched parameters are not affected.
REQ-019 FILL: rdy=0, wren=1, addr=(base+idx) mod 2^ADDR_W; idx increments by 1 each cycle.
REQ-020 First write is presented in the cycle after the accepting edge; one write per cycle, no gaps.
REQ-021 wrdata by mode, with idx zero-extended or truncated to DATA_W:
  - 0 IDENTITY: idx.
  - 1 DESCENDING: (2^ADDR_W-1-idx).
  - 2 CONSTANT: fill_val.
  - 3 XOR: idx ^ fill_val.
REQ-022 A fill of effective length L issues exactly L writes, with idx = 0..L-1.
REQ-023 On the edge ending the write with idx=L-1: state goes to IDLE, and done=1 for the following cycle with rdy=1 and wren=0.
REQ-024 Address wraps modulo 2^ADDR_W when base+idx overflows; no error is flagged.
REQ-025 abort=1 on an edge while in FILL: the write presented in that cycle completes, then the block enters IDLE with done=1 for one cycle; no further writes.
REQ-026 abort in IDLE is ignored.
REQ-027 If abort and the final write coincide, the block shows one done pulse and identical IDLE entry.
REQ-028 en=1 in the done cycle is accepted (back-to-back fills); the next FILL starts on the following cycle.
REQ-029 addr and wrdata are don't-care while wren=0 but are held stable (last value) to aid debug.

Reset
REQ-030 rst=1 on an edge forces IDLE from any state, including mid-fill.
REQ-031 Reset values: rdy=1, wren=0, done=0, addr=0, wrdata=0, idx=0, latched parameters=0.
REQ-032 rst has priority over en and abort in the same cycle.

Structure
REQ-033 Package mem_fill_pkg holds the state enum, the mode enum (IDENTITY, DESCENDING, CONSTANT, XOR), and the MODE_W=2 constant.
REQ-034 Combinational sub-module mem_fill_pattern (inputs mode, idx, fill_val; output wrdata) computes REQ-021; mem_fill instantiates it once.
REQ-035 With defaults and mode=IDENTITY, base=0, len=0, mem_fill is cycle-equivalent to the existing 256-entry init block.

Verification
REQ-036 Reset, en=1 for one cycle, mode=0, base=0, len=0 -> 256 writes with addr=wrdata=0..255, wren=1, rdy=0; then rdy=1, done pulse, wren=0 for 5 further idle cycles.
REQ-037 mode=3, fill_val=8'hA5, base=8'hFE, len=4 -> writes at addrs FE, FF, 00, 01 with data A5, A4, A7, A6; done after the 4th write.
REQ-038 mode=2, fill_val=8'h3C, len=10, abort on the 3rd write cycle -> exactly 3 writes of 3C, then done=1 and rdy=1; en pulses during FILL are ignored.
REQ-039 mode=1, len=3 -> data FF, FE, FD; en held high in the done cycle -> a second fill starts immediately with no idle gap beyond the done cycle.
REQ-040 rst asserted mid-fill (idx=100) -> next cycle rdy=1, wren=0, done=0, all outputs at reset values.
REQ-041 ADDR_W=4, DATA_W=12, mode=0, len=0 -> 16 writes with wrdata zero-extended to 12 bits, values 0..15.
